// File: rtl/sort_job_scheduler.sv
// Job scheduler for a sort core: queues array-size requests, launches the core one job at a time
// and reports per-job status. Define SORT_WATCHDOG_EN to add the hung-core watchdog and recovery reset.
module sort_job_scheduler #(
    parameter int ADDR_WDTH      = 4,
    parameter int QDEPTH_LOG2    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_WDTH:0]   cmd_size,
    output logic                 sort_start,
    output logic [ADDR_WDTH:0]   sort_arr_size,
    input  logic                 sort_done,
    input  logic                 sort_err,
    output logic                 sort_rst_n,
    output logic                 stat_valid,
    input  logic                 stat_ready,
    output logic [ADDR_WDTH:0]   stat_size,
    output logic                 stat_err,
    output logic                 stat_timeout,
    output logic [15:0]          stat_cycles,
    output logic                 busy,
    output logic [QDEPTH_LOG2:0] queue_level
);

    localparam int                   DEPTH    = 2**QDEPTH_LOG2;
    localparam logic [ADDR_WDTH:0]   MAX_SIZE = {1'b1, {ADDR_WDTH{1'b0}}};
    localparam logic [QDEPTH_LOG2:0] FULL_LVL = {1'b1, {QDEPTH_LOG2{1'b0}}};

    // The watchdog limit must fit the 16-bit cycle counter, whichever build is used.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef SORT_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT, S_RECOVER} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_REPORT} state_t;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic size_ok(input logic [ADDR_WDTH:0] sz);
        return (sz != '0) && (sz <= MAX_SIZE);
    endfunction

    logic [ADDR_WDTH:0]     mem_q [DEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [QDEPTH_LOG2:0]   level_q;
    logic                   head_vis_q;
    logic                   push, pop;
    logic [ADDR_WDTH:0]     job_size_q;

    state_t                 state_q, state_d;
    logic [15:0]            cnt_q;
    logic                   rpt_load, rpt_err;
    logic [15:0]            rpt_cyc;
    logic [ADDR_WDTH:0]     stat_size_q;
    logic                   stat_err_q;
    logic [15:0]            stat_cycles_q;
`ifdef SORT_WATCHDOG_EN
    logic                   rpt_to;
    logic                   stat_to_q;
    logic                   rec_q;
`endif

    assign cmd_ready = (level_q != FULL_LVL);
    assign push      = cmd_valid && cmd_ready;

    // Command FIFO; head_vis_q delays visibility of a new head by one cycle so a
    // command reaching an empty idle block launches two edges after it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_vis_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            head_vis_q <= (level_q != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_size;
        if (pop)  job_size_q <= mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        rpt_load = 1'b0;
        rpt_err  = 1'b0;
        rpt_cyc  = '0;
`ifdef SORT_WATCHDOG_EN
        rpt_to   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (head_vis_q && (level_q != '0)) begin
                    pop     = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Empty or oversized jobs never reach the core.
                if (size_ok(job_size_q)) begin
                    state_d = S_WAIT;
                end else begin
                    state_d  = S_REPORT;
                    rpt_load = 1'b1;
                    rpt_err  = (job_size_q != '0);
                end
            end
            S_WAIT: begin
                if (sort_done) begin
                    state_d  = S_REPORT;
                    rpt_load = 1'b1;
                    rpt_err  = sort_err;
                    rpt_cyc  = cnt_q;
                end
`ifdef SORT_WATCHDOG_EN
                else if (cnt_q == WD_LIMIT) begin
                    state_d  = S_RECOVER;
                    rpt_load = 1'b1;
                    rpt_err  = 1'b1;
                    rpt_to   = 1'b1;
                    rpt_cyc  = WD_LIMIT;
                end
            end
            S_RECOVER: begin
                if (rec_q) state_d = S_REPORT;
`endif
            end
            S_REPORT: begin
                if (stat_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            stat_size_q   <= '0;
            stat_err_q    <= 1'b0;
            stat_cycles_q <= '0;
`ifdef SORT_WATCHDOG_EN
            stat_to_q     <= 1'b0;
            rec_q         <= 1'b0;
`endif
        end else begin
            if (state_q == S_LAUNCH)    cnt_q <= 16'd1;
            else if (state_q == S_WAIT) cnt_q <= sat_inc(cnt_q);
            if (rpt_load) begin
                stat_size_q   <= job_size_q;
                stat_err_q    <= rpt_err;
                stat_cycles_q <= rpt_cyc;
`ifdef SORT_WATCHDOG_EN
                stat_to_q     <= rpt_to;
`endif
            end
`ifdef SORT_WATCHDOG_EN
            // Low in the first RECOVER cycle, high in the second: core reset lasts two cycles.
            rec_q <= (state_q == S_RECOVER);
`endif
        end
    end

    assign sort_start    = (state_q == S_LAUNCH) && size_ok(job_size_q);
    assign sort_arr_size = job_size_q;
    assign stat_valid    = (state_q == S_REPORT);
    assign stat_size     = stat_size_q;
    assign stat_err      = stat_err_q;
    assign stat_cycles   = stat_cycles_q;
    assign busy          = (state_q != S_IDLE);
    assign queue_level   = level_q;
`ifdef SORT_WATCHDOG_EN
    assign sort_rst_n    = (state_q != S_RECOVER);
    assign stat_timeout  = stat_to_q;
`else
    assign sort_rst_n    = 1'b1;
    assign stat_timeout  = 1'b0;
`endif

endmodule
